// File: rtl/alarma_ctrl.sv
// Alarm sequencer: synchronises and debounces the button, runs the arm/disarm FSM, drives LUZ/SIRENA.
// Define ALARMA_ZONE_LATCH_EN to add the ZONA output (tripped-zone latch).
module alarma_ctrl #(
    parameter int N_ZONES      = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int EXIT_DLY     = 1000,
    parameter int ENTRY_DLY    = 500,
    parameter int ALARM_TIME   = 2000,
    parameter int BLINK_HALF   = 50
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Button,
    input  logic [N_ZONES-1:0] SENSOR,
    output logic               LUZ,
    output logic               SIRENA,
    output logic [2:0]         ESTADO
`ifdef ALARMA_ZONE_LATCH_EN
    ,
    output logic [N_ZONES-1:0] ZONA
`endif
);

    localparam int MAX_DLY = (EXIT_DLY > ENTRY_DLY) ?
                             ((EXIT_DLY > ALARM_TIME) ? EXIT_DLY : ALARM_TIME) :
                             ((ENTRY_DLY > ALARM_TIME) ? ENTRY_DLY : ALARM_TIME);
    localparam int TW = $clog2(MAX_DLY + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [2:0] {
        DESARMADA = 3'd0,
        SALIDA    = 3'd1,
        ARMADA    = 3'd2,
        ENTRADA   = 3'd3,
        ALARMA    = 3'd4
    } state_t;

    logic               btn_s1_reg, btn_s2_reg;
    logic [N_ZONES-1:0] sen_s1_reg, sen_s2_reg;
    logic [DW-1:0]      db_cnt_reg;
    logic               db_level_reg, db_prev_reg;
    logic [1:0]         rdy_cnt_reg;
    logic               btn_armed_reg;
    logic               press, tripped, expiry;

    state_t             state_reg, state_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic [BW-1:0]      blink_cnt_reg, blink_cnt_next;
    logic               luz_reg, luz_next;
    logic               sirena_reg, sirena_next;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            btn_s1_reg <= 1'b0;
            btn_s2_reg <= 1'b0;
            sen_s1_reg <= '0;
            sen_s2_reg <= '0;
        end else begin
            btn_s1_reg <= Button;
            btn_s2_reg <= btn_s1_reg;
            sen_s1_reg <= SENSOR;
            sen_s2_reg <= sen_s1_reg;
        end
    end

    // A press only counts once the synced button has been seen low after reset,
    // so a button held through reset release cannot arm the system.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            db_cnt_reg    <= '0;
            db_level_reg  <= 1'b0;
            db_prev_reg   <= 1'b0;
            rdy_cnt_reg   <= 2'd0;
            btn_armed_reg <= 1'b0;
        end else begin
            db_prev_reg <= db_level_reg;
            if (rdy_cnt_reg != 2'd2)
                rdy_cnt_reg <= rdy_cnt_reg + 2'd1;
            if (rdy_cnt_reg == 2'd2 && !btn_s2_reg)
                btn_armed_reg <= 1'b1;
            if (btn_s2_reg != db_level_reg) begin
                if (db_cnt_reg == DW'(DEBOUNCE_CYC - 1)) begin
                    db_level_reg <= btn_s2_reg;
                    db_cnt_reg   <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    assign press   = db_level_reg & ~db_prev_reg & btn_armed_reg;
    assign tripped = |sen_s2_reg;
    assign expiry  = (timer_reg == '0);

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        blink_cnt_next = blink_cnt_reg;
        luz_next       = luz_reg;
        case (state_reg)
            DESARMADA: if (press) state_next = SALIDA;
            SALIDA: begin
                if (press)       state_next = DESARMADA;
                else if (expiry) state_next = ARMADA;
            end
            ARMADA: begin
                if (press)        state_next = DESARMADA;
                else if (tripped) state_next = ENTRADA;
            end
            ENTRADA: begin
                if (press)       state_next = DESARMADA;
                else if (expiry) state_next = ALARMA;
            end
            ALARMA: begin
                if (press)       state_next = DESARMADA;
                else if (expiry) state_next = ARMADA;
            end
            default: state_next = DESARMADA;
        endcase

        // Every lit state starts with LUZ on, so entry needs no per-state table.
        if (state_next != state_reg) begin
            blink_cnt_next = '0;
            luz_next       = (state_next != DESARMADA);
            case (state_next)
                SALIDA:  timer_next = TW'(EXIT_DLY - 1);
                ENTRADA: timer_next = TW'(ENTRY_DLY - 1);
                ALARMA:  timer_next = TW'(ALARM_TIME - 1);
                default: timer_next = '0;
            endcase
        end else begin
            if (timer_reg != '0)
                timer_next = timer_reg - 1'b1;
            if (state_reg == SALIDA || state_reg == ENTRADA) begin
                if (blink_cnt_reg == BW'(BLINK_HALF - 1)) begin
                    blink_cnt_next = '0;
                    luz_next       = ~luz_reg;
                end else begin
                    blink_cnt_next = blink_cnt_reg + 1'b1;
                end
            end
        end
        sirena_next = (state_next == ALARMA);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= DESARMADA;
            timer_reg     <= '0;
            blink_cnt_reg <= '0;
            luz_reg       <= 1'b0;
            sirena_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            blink_cnt_reg <= blink_cnt_next;
            luz_reg       <= luz_next;
            sirena_reg    <= sirena_next;
        end
    end

    assign LUZ    = luz_reg;
    assign SIRENA = sirena_reg;
    assign ESTADO = state_reg;

`ifdef ALARMA_ZONE_LATCH_EN
    logic [N_ZONES-1:0] zona_reg;

    // Kept through DESARMADA so the user can see which zone fired after disarming.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            zona_reg <= '0;
        end else if (state_next == SALIDA && state_reg != SALIDA) begin
            zona_reg <= '0;
        end else if (state_reg == ARMADA && state_next == ENTRADA) begin
            zona_reg <= sen_s2_reg;
        end else if (state_reg == ENTRADA || state_reg == ALARMA) begin
            zona_reg <= zona_reg | sen_s2_reg;
        end
    end

    assign ZONA = zona_reg;
`endif

endmodule

// File: tb/tb_alarma_ctrl.sv
// Directed bench for alarma_ctrl: reset, bounce rejection, arming, intrusion, disarm priority, async reset.
module tb_alarma_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Button = 1'b0;
    logic [3:0] SENSOR = 4'b0000;
    logic       LUZ, SIRENA;
    logic [2:0] ESTADO;
`ifdef ALARMA_ZONE_LATCH_EN
    logic [3:0] ZONA;
`endif

    int total = 0;
    int bad   = 0;

    alarma_ctrl #(
        .N_ZONES(4), .DEBOUNCE_CYC(4), .EXIT_DLY(20),
        .ENTRY_DLY(10), .ALARM_TIME(30), .BLINK_HALF(2)
    ) dut (
        .CLK(CLK), .RST(RST), .Button(Button), .SENSOR(SENSOR),
        .LUZ(LUZ), .SIRENA(SIRENA), .ESTADO(ESTADO)
`ifdef ALARMA_ZONE_LATCH_EN
        , .ZONA(ZONA)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic blink(input int idx);
        return ((idx / 2) % 2) == 0;
    endfunction

    task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
        int n = 0;
        while (ESTADO !== s && n < lim) begin
            step();
            n++;
        end
        chk(tag, n, {29'd0, ESTADO}, {29'd0, s});
    endtask

    initial begin
        logic [2:0] e_st;
        logic       e_luz;

        // Reset held for 3 cycles, then 100 idle cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_luz", i, LUZ, 1'b0);
            chk("rst_sirena", i, SIRENA, 1'b0);
            chk("rst_estado", i, ESTADO, 3'd0);
        end
        RST = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_estado", i, ESTADO, 3'd0);
            chk("idle_luz", i, LUZ, 1'b0);
            chk("idle_sirena", i, SIRENA, 1'b0);
        end

        // Bounce: 2 cycles high / 2 low never survives a 4-cycle debounce.
        for (int i = 0; i < 20; i++) begin
            Button = ((i / 2) % 2) == 0;
            step();
            chk("bounce_estado", i, ESTADO, 3'd0);
        end
        Button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bounce_tail", i, ESTADO, 3'd0);
        end

        // Arm: SALIDA from cycle 7 to 26, ARMADA from 27.
        Button = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i < 7)       begin e_st = 3'd0; e_luz = 1'b0;         end
            else if (i < 27) begin e_st = 3'd1; e_luz = blink(i - 7); end
            else             begin e_st = 3'd2; e_luz = 1'b1;         end
            chk("arm_estado", i, ESTADO, e_st);
            chk("arm_luz", i, LUZ, e_luz);
            chk("arm_sirena", i, SIRENA, 1'b0);
            if (i == 10) Button = 1'b0;
        end

        // Intrusion: ENTRADA 3..12, ALARMA 13..42, back to ARMADA at 43.
        SENSOR = 4'b0100;
        for (int i = 1; i <= 46; i++) begin
            step();
            SENSOR = 4'b0000;
            if (i < 3)       begin e_st = 3'd2; e_luz = 1'b1;         end
            else if (i < 13) begin e_st = 3'd3; e_luz = blink(i - 3); end
            else if (i < 43) begin e_st = 3'd4; e_luz = 1'b1;         end
            else             begin e_st = 3'd2; e_luz = 1'b1;         end
            chk("intr_estado", i, ESTADO, e_st);
            chk("intr_luz", i, LUZ, e_luz);
            chk("intr_sirena", i, SIRENA, (e_st == 3'd4));
        end
`ifdef ALARMA_ZONE_LATCH_EN
        chk("intr_zona", 0, ZONA, 4'b0100);
`endif

        // Disarm priority: press reaches the FSM on the same edge ENTRADA expires.
        SENSOR = 4'b0100;
        for (int i = 1; i <= 50; i++) begin
            step();
            SENSOR = 4'b0000;
            if (i == 6)  Button = 1'b1;
            if (i == 16) Button = 1'b0;
            if (i < 3)       e_st = 3'd2;
            else if (i < 13) e_st = 3'd3;
            else             e_st = 3'd0;
            chk("prio_estado", i, ESTADO, e_st);
            chk("prio_sirena", i, SIRENA, 1'b0);
            if (i >= 13) chk("prio_luz", i, LUZ, 1'b0);
        end
`ifdef ALARMA_ZONE_LATCH_EN
        chk("prio_zona_hold", 0, ZONA, 4'b0100);
`endif

        // Drive to ALARMA again, then reset asynchronously mid-cycle.
        Button = 1'b1;
        for (int i = 0; i < 10; i++) step();
        Button = 1'b0;
        wait_state("to_armada", 3'd2, 60);
        SENSOR = 4'b0001;
        step();
        SENSOR = 4'b0000;
        wait_state("to_alarma", 3'd4, 40);
        chk("pre_rst_sirena", 0, SIRENA, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        chk("async_sirena", 0, SIRENA, 1'b0);
        chk("async_estado", 0, ESTADO, 3'd0);
        chk("async_luz", 0, LUZ, 1'b0);
`ifdef ALARMA_ZONE_LATCH_EN
        chk("async_zona", 0, ZONA, 4'b0000);
`endif

        // Button held across reset release must not arm.
        Button = 1'b1;
        for (int i = 0; i < 3; i++) step();
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("held_estado", i, ESTADO, 3'd0);
        end
        Button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("held_rel_estado", i, ESTADO, 3'd0);
        end
        Button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) chk("repress_before", i, ESTADO, 3'd0);
            if (i == 7) chk("repress_salida", i, ESTADO, 3'd1);
        end
        Button = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarma_ctrl.md
Name: alarma_ctrl

Overview:
- Sequencer for the alarm system: debounces the user Button, runs the arm/disarm state machine, watches the zone sensors and drives the indicator light LUZ and the siren.
- Sits between the board pins (Button, sensors) and the output drivers. The testbench drives Button/RST and observes LUZ exactly as for the basic alarm.

Parameters:
N_ZONES, 4, number of sensor inputs
DEBOUNCE_CYC, 16, cycles Button must be stable before the debounced level changes (>=1)
EXIT_DLY, 1000, cycles spent in SALIDA before arming (>=1)
ENTRY_DLY, 500, cycles spent in ENTRADA before alarm (>=1)
ALARM_TIME, 2000, cycles SIRENA stays on before auto re-arm (>=1)
BLINK_HALF, 50, LUZ half-period in cycles when blinking (>=1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
Button  input  1  raw push-button, asynchronous, high = pressed
SENSOR  input  N_ZONES  raw zone sensors, asynchronous, high = tripped
LUZ  output  1  indicator light
SIRENA  output  1  siren enable
ESTADO  output  3  current state code

Behaviour:
- Reset (RST=0, async) forces the following; release is synchronous to CLK.
  - Outputs: LUZ=0, SIRENA=0, ESTADO=0 (DESARMADA).
  - Internal state: all sync flops, debounce counter, timer and blink counter cleared; debounced level = 0.
- Input sync: Button and SENSOR each pass through a 2-flop synchronizer.
- Debounce:
  - Counter restarts whenever the synced Button differs from the debounced level.
  - When it has differed for DEBOUNCE_CYC consecutive cycles, the debounced level takes the new value.
- Press pulse (press): 1-cycle pulse on the 0->1 edge of the debounced level.
  - Latency from raw Button rise to press = 2 + DEBOUNCE_CYC + 1 cycles.
  - Release generates no event.
- Tripped = OR of the synced SENSOR bits.
- Timer: a single down-counter. On entering a timed state it loads (delay-1), and expiry fires when it is 0. A timed state therefore lasts exactly its delay in cycles.
- States (ESTADO code):
  - DESARMADA=0: press -> SALIDA.
  - SALIDA=1: press -> DESARMADA; expiry after EXIT_DLY -> ARMADA. Sensors are ignored.
  - ARMADA=2: press -> DESARMADA; tripped -> ENTRADA.
  - ENTRADA=3: press -> DESARMADA; expiry after ENTRY_DLY -> ALARMA.
  - ALARMA=4: press -> DESARMADA; expiry after ALARM_TIME -> ARMADA.
  - Codes 5-7 are illegal and go to DESARMADA next cycle.
- Priority in the same cycle: press > expiry > tripped.
- ARMADA entered with tripped already high goes to ENTRADA on the next cycle. No hold-off is applied.
- Outputs are registered and follow ESTADO with the same-cycle update, i.e. they reflect the new state in the cycle after the transition.
  - LUZ: DESARMADA 0; ARMADA 1; ALARMA 1.
  - LUZ in SALIDA and ENTRADA blinks. It starts at 1 on state entry and toggles every BLINK_HALF cycles. The blink counter restarts on every state change.
  - SIRENA=1 only in ALARMA.
- Reset mid-operation: immediate return to reset values. No press is generated by a Button already held at reset release until it is released and pressed again.

Optional Feature:
- Macro: ALARMA_ZONE_LATCH_EN.
- Defined:
  - Adds output ZONA (N_ZONES bits) holding the synced SENSOR vector captured on the ARMADA->ENTRADA transition.
  - Bits are OR-accumulated while in ENTRADA and ALARMA.
  - ZONA clears on entry to SALIDA and on reset; it holds its value in DESARMADA so the user can read it after disarming.
- Not defined: no ZONA port and no latch logic.

Test Plan (DEBOUNCE_CYC=4, EXIT_DLY=20, ENTRY_DLY=10, ALARM_TIME=30, BLINK_HALF=2):
- Reset then idle: RST low for 3 cycles, release -> LUZ=0, SIRENA=0, ESTADO=0 held for 100 cycles.
- Arm sequence: Button high for 10 cycles -> ESTADO=1 appears 7-8 cycles after the rise, LUZ pattern 1,1,0,0,... for 20 cycles, then ESTADO=2 and LUZ=1.
- Bounce rejection: Button toggling every 2 cycles for 20 cycles, then low -> ESTADO stays 0.
- Intrusion: armed, SENSOR=4'b0100 for 1 cycle -> ESTADO=3 three cycles later; after 10 cycles ESTADO=4, SIRENA=1 for exactly 30 cycles, then ESTADO=2. With ALARMA_ZONE_LATCH_EN, ZONA=4'b0100.
- Disarm priority: the press pulse is timed to coincide with the ENTRADA expiry cycle -> ESTADO=0, SIRENA never asserts.
- Async reset while ESTADO=4: RST low between clock edges -> SIRENA=0 and ESTADO=0 before the next CLK edge.
